// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI transmitter peripheral.
package midi_pkg;

  localparam int unsigned MIDI_BAUD = 31250;

  // Word offsets, as seen on mem_addr_i[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS register bit positions.
  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : write request and data (ignored when full unless popping)
//   pop           : read request, advances head when non-empty
//   flush         : empties the FIFO; a simultaneous push is discarded
//   rdata_c       : current head entry (combinational)
//   full_c/empty_c: occupancy flags (combinational)
//   level         : number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);
  assign rdata_c = mem_q[rd_ptr_q];
  assign level   = level_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty_c & ~flush;
  assign push_ok = push & ~flush & (~full_c | pop_ok);

  // Storage array.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/midi_out.sv
// MIDI transmitter: MMIO-written bytes are queued and sent as 8N1 frames.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   select_i             : bus select for this peripheral
//   mem_ready_o          : one-cycle transaction-complete pulse
//   mem_wstrb_i          : byte write strobes, all zero means read
//   mem_addr_i           : byte address, [3:2] decoded
//   mem_wdata_i          : write data
//   mem_rdata_o          : read data, valid with mem_ready_o
//   midi_o               : serial output, idle high
module midi_out
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned BAUD       = MIDI_BAUD,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        select_i,
  output logic        mem_ready_o,
  input  logic [3:0]  mem_wstrb_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        midi_o
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

  // Bus decode.
  logic        is_write;
  logic        act;
  logic [1:0]  reg_sel;
  logic        push_req;
  logic        flush_req;
  logic        ovf_clr;
  logic        ovf_q;
  logic [31:0] rdata_d;

  // FIFO interface.
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  // Serialiser.
  tx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           midi_d;
  logic           bit_end;

  logic unused_ok;
  assign unused_ok = ^{mem_addr_i[31:4], mem_addr_i[1:0], mem_wdata_i[31:8]};

  assign is_write = |mem_wstrb_i;
  assign reg_sel  = mem_addr_i[3:2];
  // Side effects fire only in the ready cycle, so each transaction acts once.
  assign act       = mem_ready_o & select_i & is_write;
  assign push_req  = act & (reg_sel == REG_DATA) & mem_wstrb_i[0];
  assign flush_req = act & (reg_sel == REG_STATUS) & mem_wdata_i[0];
  assign ovf_clr   = act & (reg_sel == REG_STATUS) & mem_wdata_i[3];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push_req),
    .wdata   (mem_wdata_i[7:0]),
    .pop     (fifo_pop),
    .flush   (flush_req),
    .rdata_c (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level   (fifo_level)
  );

  // Read mux, sampled in the request cycle and presented with the ready pulse.
  always_comb begin
    rdata_d = '0;
    if (!is_write && reg_sel == REG_STATUS) begin
      rdata_d[ST_FULL]  = fifo_full;
      rdata_d[ST_EMPTY] = fifo_empty;
      rdata_d[ST_BUSY]  = (state_q != IDLE);
      rdata_d[ST_OVF]   = ovf_q;
      rdata_d[15:8]     = 8'(fifo_level);
    end
  end

  // Bus handshake and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_ready_o <= select_i & ~mem_ready_o;
      mem_rdata_o <= (select_i & ~mem_ready_o) ? rdata_d : '0;
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (push_req & fifo_full & ~fifo_pop & ~flush_req) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bit_end = (cnt_q == CW'(DIV - 1));

  // Serialiser next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    midi_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Back-to-back frames: pop straight into the next start bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Output level follows the state being entered, keeping midi_o registered.
    unique case (state_d)
      START:   midi_d = 1'b0;
      DATA:    midi_d = shift_d[0];
      default: midi_d = 1'b1;
    endcase
  end

  // Serialiser state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      midi_o  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      midi_o  <= midi_d;
    end
  end

endmodule
